// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with a combinational result and a one-cycle registered copy.
// Optional signed-overflow outputs (ovf, ovf_q) are enabled by defining FULL_ADDER_OVF_EN.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the whole chain.
  logic [WIDTH:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  // Valid semantics: in_valid high at a rising clk edge captures the current
  // combinational result; out_valid is in_valid delayed by one cycle. There is
  // no back-pressure, so a new transaction may be presented every cycle and
  // sum_q/c_out_q hold their last captured value when in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        c_out_q <= c_out;
`ifdef FULL_ADDER_OVF_EN
        ovf_q   <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1 truth table, WIDTH=8 directed vectors and reset, WIDTH=16 streaming.
// Registered results are checked by a monitor popping an expected queue on out_valid.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- WIDTH=1 instance ----------------
  logic       a1, b1, ci1;
  logic       iv1 = 1'b0;
  logic       s1, co1, sq1, coq1, ov1;
  logic       f1, fq1;

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1), .in_valid(iv1),
    .sum(s1), .c_out(co1), .sum_q(sq1), .c_out_q(coq1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f1), .ovf_q(fq1)
`endif
  );

  // ---------------- WIDTH=8 instance ----------------
  logic [7:0] a8, b8, s8, sq8;
  logic       ci8, iv8, co8, coq8, ov8;
  logic       f8, fq8;
  logic [9:0] exp_q8[$];

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8), .in_valid(iv8),
    .sum(s8), .c_out(co8), .sum_q(sq8), .c_out_q(coq8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f8), .ovf_q(fq8)
`endif
  );

  // ---------------- WIDTH=16 instance ----------------
  logic [15:0] a16, b16, s16, sq16;
  logic        ci16, iv16, co16, coq16, ov16;
  logic        f16, fq16;
  logic [17:0] exp_q16[$];

  full_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .c_in(ci16), .in_valid(iv16),
    .sum(s16), .c_out(co16), .sum_q(sq16), .c_out_q(coq16), .out_valid(ov16)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f16), .ovf_q(fq16)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic eco, input logic eovf);
    a8 = a; b8 = b; ci8 = c; iv8 = 1'b1;
    exp_q8.push_back({eovf, eco, es});
    #1;
    chk("u8_comb_sum", s8, es);
    chk("u8_comb_cout", co8, eco);
`ifdef FULL_ADDER_OVF_EN
    chk("u8_comb_ovf", f8, eovf);
`endif
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic eco, input logic eovf);
    @(negedge clk);
    drive8(a, b, c, es, eco, eovf);
  endtask

  task automatic idle8();
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] full;
    logic        eovf;
    full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    eovf = (a[15] == b[15]) && (full[15] != a[15]);
    @(negedge clk);
    a16 = a; b16 = b; ci16 = c; iv16 = 1'b1;
    exp_q16.push_back({eovf, full});
    #1;
    chk("u16_comb_sum", s16, full[15:0]);
    chk("u16_comb_cout", co16, full[16]);
`ifdef FULL_ADDER_OVF_EN
    chk("u16_comb_ovf", f16, eovf);
`endif
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    if (ov8) begin
      if (exp_q8.size() == 0) chk("u8_spurious_valid", ov8, 1'b0);
      else begin
        e = exp_q8.pop_front();
        chk("u8_sum_q", sq8, e[7:0]);
        chk("u8_c_out_q", coq8, e[8]);
`ifdef FULL_ADDER_OVF_EN
        chk("u8_ovf_q", fq8, e[9]);
`endif
      end
    end
  end

  always @(posedge clk) begin
    logic [17:0] e;
    #1;
    if (ov16) begin
      if (exp_q16.size() == 0) chk("u16_spurious_valid", ov16, 1'b0);
      else begin
        e = exp_q16.pop_front();
        chk("u16_sum_q", sq16, e[15:0]);
        chk("u16_c_out_q", coq16, e[16]);
`ifdef FULL_ADDER_OVF_EN
        chk("u16_ovf_q", fq16, e[17]);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  // Truth table rows: {a,b,c_in} -> {ovf, c_out, sum}
  logic [2:0] tt_exp [8] = '{3'b000, 3'b101, 3'b001, 3'b010,
                             3'b001, 3'b010, 3'b110, 3'b011};

  initial begin
    a1 = 0; b1 = 0; ci1 = 0;
    a8 = 0; b8 = 0; ci8 = 0; iv8 = 0;
    a16 = 0; b16 = 0; ci16 = 0; iv16 = 0;
    #1;
    chk("rst_u8_sum_q", sq8, 8'h00);
    chk("rst_u8_c_out_q", coq8, 1'b0);
    chk("rst_u8_out_valid", ov8, 1'b0);
    chk("rst_u16_out_valid", ov16, 1'b0);

    // WIDTH=1 sweep, run while rst is still high to show the combinational path ignores it
    for (int i = 0; i < 8; i++) begin
      {a1, b1, ci1} = i[2:0];
      #1;
      chk("u1_sum", s1, tt_exp[i][0]);
      chk("u1_cout", co1, tt_exp[i][1]);
`ifdef FULL_ADDER_OVF_EN
      chk("u1_ovf", f1, tt_exp[i][2]);
`endif
      #9;
    end

    // Transaction held during reset is captured on the first edge after release
    @(negedge clk);
    drive8(8'hA0, 8'hC0, 1'b0, 8'h60, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("u8_no_capture_in_rst", ov8, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    send8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    send8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    idle8();
    @(posedge clk); #1;
    chk("u8_valid_drop", ov8, 1'b0);
    chk("u8_sum_q_hold", sq8, 8'h47);
    chk("u8_c_out_q_hold", coq8, 1'b0);

    // Async reset between edges after capturing all-ones + all-ones + 1
    send8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    idle8();
    #2 rst = 1'b1;
    #1;
    chk("arst_sum_q", sq8, 8'h00);
    chk("arst_c_out_q", coq8, 1'b0);
    chk("arst_out_valid", ov8, 1'b0);
    chk("arst_comb_sum", s8, 8'hFF);
    chk("arst_comb_cout", co8, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=16 back-to-back stream: directed corners then pseudo-random operands
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    send16(16'h0000, 16'h0000, 1'b0);
    send16(16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 1000; i++)
      send16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)));
    @(negedge clk);
    iv16 = 1'b0;
    repeat (3) @(negedge clk);

    chk("u8_queue_drained", 64'(exp_q8.size()), 64'd0);
    chk("u16_queue_drained", 64'(exp_q16.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Binary adder cell with a parameterizable width. Computes sum = a + b + c_in combinationally, with carry out.
- Also provides a one-cycle registered copy of the result plus a valid flag, so pipelined datapaths can use it directly.
- Default width 1 gives the classic 1-bit full adder used as the leaf cell of ripple and carry-select adders.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered stage.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry in, weight 1.
- in_valid  input  1  marks a,b,c_in as a transaction to capture on the next rising clk edge.
- sum  output  WIDTH  combinational sum, (a+b+c_in) mod 2^WIDTH.
- c_out  output  1  combinational carry out, bit WIDTH of a+b+c_in.
- sum_q  output  WIDTH  registered sum.
- c_out_q  output  1  registered carry out.
- out_valid  output  1  registered in_valid.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Combinational path:
  - {c_out, sum} = a + b + c_in, computed at WIDTH+1 bits with no truncation of the carry.
  - Zero latency and independent of clk/rst; outputs settle within the same delta/timestep as the inputs change.
  - Implemented as a ripple chain of per-bit cells.
  - Per-bit rule: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = c_in.
  - WIDTH=1 truth table (a,b,c_in -> sum,c_out):
    - 000->0,0; 001->1,0; 010->1,0; 011->0,1
    - 100->1,0; 101->0,1; 110->0,1; 111->1,1.
- Registered path, latency 1 cycle:
  - On a rising clk with in_valid=1: sum_q<=sum, c_out_q<=c_out, out_valid<=1.
  - On a rising clk with in_valid=0: out_valid<=0; sum_q and c_out_q hold their previous values.
- Reset:
  - While rst=1, sum_q=0, c_out_q=0, out_valid=0, immediately and without waiting for clk.
  - Combinational outputs are unaffected by rst.
  - Deasserting rst mid-stream: the first capture happens on the first rising clk edge with rst=0.
- Boundaries:
  - All-ones + all-ones + 1 -> sum all-ones, c_out=1.
  - All-zero inputs -> sum=0, c_out=0.
  - X/Z on inputs propagates; no masking.
- No handshake back-pressure; a new transaction may be presented every cycle.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, combinational) and ovf_q (1 bit, registered under the same rules as c_out_q, reset 0).
  - ovf = c_WIDTH ^ c_(WIDTH-1), i.e. two's-complement signed overflow. For WIDTH=1 this is c_out ^ c_in.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- WIDTH=1, step a,b,c_in through 000..111, 10 ns each, no reset dependence -> sum/c_out match the truth table above at every step.
- WIDTH=8:
  - a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1.
  - a=8'h7F, b=8'h00, c_in=1 -> sum=8'h80, c_out=0; ovf=1 with FULL_ADDER_OVF_EN.
- WIDTH=8, in_valid=1, a=8'h12, b=8'h34, c_in=1 at edge N -> at edge N: sum_q=8'h47, c_out_q=0, out_valid=1. At edge N+1 with in_valid=0 -> out_valid=0, sum_q stays 8'h47.
- Assert rst between clock edges after a capture of 8'hFF+8'hFF+1 -> sum_q=0, c_out_q=0, out_valid=0 immediately. Combinational sum stays 8'hFF, c_out=1.
- WIDTH=16, 1000 random a,b,c_in with in_valid=1 -> combinational and registered results match a reference a+b+c_in (registered lagging by one cycle).
